// File: rtl/stdp_weight_update.sv
// Pair-based STDP learning stage for a single synapse.
//
// Tracks decaying pre- and post-synaptic spike traces and applies a two-stage
// pipelined, saturating weight update on every spike rising edge.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         single-cycle trace decay strobe
//   learn_en     enables weight updates (traces always run)
//   pre_spike    presynaptic spike level (rising edge = event)
//   post_spike   postsynaptic spike level (rising edge = event)
//   weight_load  synchronous load of weight_in (highest priority)
//   weight_in    value loaded by weight_load
//   weight       registered synaptic weight
//   weight_valid one-cycle pulse when an STDP update is applied
//   pre_trace    registered presynaptic trace
//   post_trace   registered postsynaptic trace
module stdp_weight_update #(
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned TRACE_WIDTH = 8,
  parameter int unsigned W_INIT      = 64,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned LTP_SHIFT   = 2,
  parameter int unsigned LTD_SHIFT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   learn_en,
  input  logic                   pre_spike,
  input  logic                   post_spike,
  input  logic                   weight_load,
  input  logic [W_WIDTH-1:0]     weight_in,
  output logic [W_WIDTH-1:0]     weight,
  output logic                   weight_valid,
  output logic [TRACE_WIDTH-1:0] pre_trace,
  output logic [TRACE_WIDTH-1:0] post_trace
);

  // Two guard bits: one for overflow above the max, one for the sign.
  localparam int unsigned SumWidth = W_WIDTH + 2;

  logic                   pre_q, post_q;
  logic                   pre_ev, post_ev;
  logic [TRACE_WIDTH-1:0] pre_trace_q, pre_trace_d;
  logic [TRACE_WIDTH-1:0] post_trace_q, post_trace_d;
  logic [TRACE_WIDTH-1:0] dp_q, dp_d;
  logic [TRACE_WIDTH-1:0] dd_q, dd_d;
  logic                   pending_q, pending_d;
  logic [W_WIDTH-1:0]     weight_q, weight_d;
  logic                   valid_q, valid_d;
  logic signed [SumWidth-1:0] sum;
  logic [W_WIDTH-1:0]     clamped;

  // Decay by trace >> DECAY_SHIFT, at least 1, so small traces still reach 0.
  function automatic logic [TRACE_WIDTH-1:0] decay_step(input logic [TRACE_WIDTH-1:0] t);
    logic [TRACE_WIDTH-1:0] dec;
    dec = t >> DECAY_SHIFT;
    if (dec == '0) dec = TRACE_WIDTH'(1);
    return (t == '0) ? t : t - dec;
  endfunction

  assign pre_ev  = pre_spike & ~pre_q;
  assign post_ev = post_spike & ~post_q;

  always_comb begin
    pre_trace_d  = pre_trace_q;
    post_trace_d = post_trace_q;
    if (pre_ev)    pre_trace_d = '1;
    else if (tick) pre_trace_d = decay_step(pre_trace_q);
    if (post_ev)   post_trace_d = '1;
    else if (tick) post_trace_d = decay_step(post_trace_q);
  end

  // Stage 1: deltas use the traces as they were before this edge.
  always_comb begin
    dp_d      = post_ev ? (pre_trace_q >> LTP_SHIFT) : '0;
    dd_d      = pre_ev ? (post_trace_q >> LTD_SHIFT) : '0;
    pending_d = (pre_ev | post_ev) & learn_en & ~weight_load;
  end

  // Stage 2: saturating signed update.
  always_comb begin
    sum = signed'(SumWidth'(weight_q)) + signed'(SumWidth'(dp_q))
        - signed'(SumWidth'(dd_q));
    if (sum[SumWidth-1])     clamped = '0;
    else if (sum[W_WIDTH])   clamped = '1;
    else                     clamped = sum[W_WIDTH-1:0];

    weight_d = weight_q;
    valid_d  = 1'b0;
    if (weight_load) begin
      weight_d = weight_in;
    end else if (pending_q) begin
      weight_d = clamped;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= 1'b0;
      post_q       <= 1'b0;
      pre_trace_q  <= '0;
      post_trace_q <= '0;
      dp_q         <= '0;
      dd_q         <= '0;
      pending_q    <= 1'b0;
      weight_q     <= W_WIDTH'(W_INIT);
      valid_q      <= 1'b0;
    end else begin
      pre_q        <= pre_spike;
      post_q       <= post_spike;
      pre_trace_q  <= pre_trace_d;
      post_trace_q <= post_trace_d;
      dp_q         <= dp_d;
      dd_q         <= dd_d;
      pending_q    <= pending_d;
      weight_q     <= weight_d;
      valid_q      <= valid_d;
    end
  end

  assign weight       = weight_q;
  assign weight_valid = valid_q;
  assign pre_trace    = pre_trace_q;
  assign post_trace   = post_trace_q;

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Synaptic learning stage directly downstream of the neuron: consumes the neuron's output spike (post) and its input spike (pre).
- Maintains decaying pre- and post-synaptic spike traces.
- Applies pair-based STDP to one saturating synaptic weight that feeds back into the neuron's integrator.
- Trace decay is paced by a `tick` strobe from the design's MAX_COUNT prescaler.

Parameters:
- W_WIDTH, 8, weight width in bits (unsigned).
- TRACE_WIDTH, 8, trace width in bits (unsigned); a spike sets the trace to all ones (TRACE_MAX).
- W_INIT, 64, weight value after reset.
- DECAY_SHIFT, 3, per-tick decay amount is trace >> DECAY_SHIFT.
- LTP_SHIFT, 2, potentiation amount is pre_trace >> LTP_SHIFT.
- LTD_SHIFT, 2, depression amount is post_trace >> LTD_SHIFT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle decay strobe from the prescaler.
- learn_en  in  1  1 = weight updates allowed; traces run regardless.
- pre_spike  in  1  presynaptic spike level; the rising edge is the event.
- post_spike  in  1  neuron output spike level; the rising edge is the event.
- weight_load  in  1  synchronous load of weight_in.
- weight_in  in  W_WIDTH  value for weight_load.
- weight  out  W_WIDTH  current synaptic weight, registered.
- weight_valid  out  1  one-cycle pulse when an STDP update has been applied.
- pre_trace  out  TRACE_WIDTH  registered presynaptic trace.
- post_trace  out  TRACE_WIDTH  registered postsynaptic trace.

Behaviour:
- Reset (async, rst_n=0):
  - weight=W_INIT.
  - pre_trace=post_trace=0, weight_valid=0.
  - Edge-detect registers=0, pending flag=0.
  - All state is discarded immediately, including any pending update.
- Event detection:
  - pre_ev = pre_spike & ~pre_q, and likewise post_ev; pre_q/post_q are the previous-cycle registers.
  - A held-high spike yields exactly one event.
- Trace update at each edge, per trace:
  - On its event: trace <= TRACE_MAX. The event wins over a coincident tick.
  - Else if tick and trace != 0: trace <= trace - max(trace >> DECAY_SHIFT, 1).
  - Otherwise the trace holds; it never underflows below 0.
- Stage 1, at the edge where an event is sampled (edge k), using trace values from BEFORE this edge:
  - dp <= post_ev ? pre_trace >> LTP_SHIFT : 0.
  - dd <= pre_ev ? post_trace >> LTD_SHIFT : 0.
  - pending <= (pre_ev | post_ev) & learn_en.
- Stage 2, at edge k+1, if pending:
  - weight <= clamp(weight + dp - dd, 0, 2^W_WIDTH-1), computed in W_WIDTH+2-bit signed arithmetic.
  - weight_valid=1 for exactly that one cycle; otherwise weight_valid=0.
- Latency: spike edge sampled at edge k → weight and weight_valid visible after edge k+1.
- Back-to-back events on consecutive cycles pipeline; each is applied one cycle after detection.
- Simultaneous pre and post events: both dp and dd use pre-event traces; the net delta is applied once.
- weight_load has highest priority:
  - weight <= weight_in.
  - Clears pending for that edge; weight_valid=0.
  - Traces are unaffected.
- learn_en=0: no pending is generated and the weight holds. learn_en is sampled at stage 1 only.

Test Plan:
- Reset → weight=64, pre_trace=post_trace=0, weight_valid=0; assert rst_n=0 mid-update → pending dropped, weight=64, no weight_valid pulse.
- Potentiation (LTP):
  - Stimulus: pre rise; one tick; then post rise.
  - pre rise → pre_trace=255, weight stays 64 with a weight_valid pulse (dp=dd=0).
  - One tick → pre_trace=224.
  - post rise → one cycle later weight=120 (dp=56), weight_valid pulse, post_trace=255.
- Depression (LTD) with saturation:
  - With post_trace=255 and no tick, pre rise → weight 64→1 (dd=63).
  - Second pre rise → weight clamps to 0.
- High saturation: weight_load 250, pre rise (pre_trace=255), post rise → weight=255 (not 57); weight_valid pulses.
- Simultaneous events:
  - Both rise with both traces 0 → weight unchanged at 64, both traces become 255.
  - After 1 tick (both 224), both rise again → dp=dd=56, weight stays 64, weight_valid pulses.
- Decay floor and gating:
  - pre_trace=5 with successive ticks → 4,3,2,1,0,0.
  - learn_en=0 with a post rise → weight unchanged, no weight_valid pulse.
  - weight_load 100 on the cycle after an event → weight=100, no pulse.
